// File: rtl/cm3_log_pkg.sv
// Shared definitions for the log accelerator AHB-Lite front end:
// register offsets, STATUS/CTRL bit positions and data-phase states.
package cm3_log_pkg;

  localparam logic [1:0] ADDR_DATA_IN  = 2'd0;
  localparam logic [1:0] ADDR_DATA_OUT = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam int ST_IN_CNT    = 0;
  localparam int ST_OUT_CNT   = 8;
  localparam int ST_IN_FULL   = 16;
  localparam int ST_OUT_EMPTY = 17;
  localparam int ST_OVF       = 18;
  localparam int ST_UNF       = 19;
  localparam int ST_BUSY      = 20;

  localparam int CTRL_BLOCK = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_CLR   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_STALL_WR,
    S_STALL_RD
  } state_e;

endpackage

// File: rtl/cm3_log_fifo.sv
// Synchronous FIFO with flush; head is visible combinationally.
// Push on a full FIFO is accepted only together with a pop.
module cm3_log_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [AW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == AW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + AW'(do_push) - AW'(do_pop);
    end
  end

endmodule

// File: rtl/cm3_log_mc.sv
// AHB-Lite slave front end for the log core: operand/result FIFOs,
// credit-based issue and per-access stall-or-flag error handling.
module cm3_log_mc
  import cm3_log_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH) + 1
) (
  input  logic          hclk,
  input  logic          rst_n,
  input  logic          hready_i,
  input  logic          hsel,
  input  logic          hwrite,
  input  logic [1:0]    htrans,
  input  logic [15:0]   haddr,
  input  logic [31:0]   hwdata,
  output logic          hresp,
  output logic          hready_o,
  output logic [31:0]   hrdata,
  output logic [DW-1:0] data_a,
  output logic          data_a_valid,
  input  logic          data_a_ready,
  input  logic [DW-1:0] data_log,
  input  logic          data_log_valid
);

  state_e        state_q, state_d;
  logic [1:0]    addr_q;
  logic          block_q, block_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] infl_q, infl_d;
  logic [AW-1:0] disc_q, disc_d;

  logic          in_push, in_pop, in_full, in_empty;
  logic          out_push, out_pop, out_full, out_empty;
  logic [DW-1:0] in_head, out_head;
  logic [AW-1:0] in_cnt, out_cnt;

  logic [AW:0]   used;
  logic          accept, issue, ret, drop;
  logic          done, bypass, flush, clr;
  logic          ovf_set, unf_set;
  logic [31:0]   status;
  logic [31:0]   rdata;
  logic          unused_ok;

  assign unused_ok = ^{haddr[15:4], haddr[1:0], htrans[0],
                       hwdata, out_full};

  assign accept       = hready_i & hsel & htrans[1];
  assign used         = {1'b0, infl_q} + {1'b0, out_cnt};
  assign issue        = ~in_empty & (used < (AW+1)'(DEPTH));
  assign in_pop       = issue & data_a_ready;
  assign data_a_valid = issue;
  assign data_a       = issue ? in_head : '0;
  assign ret          = data_log_valid;
  // results launched before a flush are dropped, not stored
  assign drop         = ret & (disc_q != '0);
  assign out_push     = ret & ~drop & ~bypass;
  assign hresp        = 1'b0;
  assign hrdata       = rdata;

  cm3_log_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_in_fifo (
    .clk_i   (hclk),
    .rst_ni  (rst_n),
    .push_i  (in_push),
    .data_i  (hwdata[DW-1:0]),
    .pop_i   (in_pop),
    .flush_i (flush),
    .data_o  (in_head),
    .count_o (in_cnt),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  cm3_log_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_out_fifo (
    .clk_i   (hclk),
    .rst_ni  (rst_n),
    .push_i  (out_push),
    .data_i  (data_log),
    .pop_i   (out_pop),
    .flush_i (flush),
    .data_o  (out_head),
    .count_o (out_cnt),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  always_comb begin
    status               = '0;
    status[ST_IN_CNT+:5]  = 5'(in_cnt);
    status[ST_OUT_CNT+:5] = 5'(out_cnt);
    status[ST_IN_FULL]   = in_full;
    status[ST_OUT_EMPTY] = out_empty;
    status[ST_OVF]       = ovf_q;
    status[ST_UNF]       = unf_q;
    status[ST_BUSY]      = (infl_q != '0);
  end

  always_comb begin
    state_d  = state_q;
    hready_o = 1'b1;
    rdata    = '0;
    done     = 1'b1;
    in_push  = 1'b0;
    out_pop  = 1'b0;
    bypass   = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    flush    = 1'b0;
    clr      = 1'b0;
    block_d  = block_q;
    unique case (state_q)
      S_WR, S_STALL_WR: begin
        unique case (1'b1)
          addr_q == ADDR_DATA_IN: begin
            if (!in_full || in_pop) in_push = 1'b1;
            else if (block_q)       done    = 1'b0;
            else                    ovf_set = 1'b1;
          end
          addr_q == ADDR_CTRL: begin
            block_d = hwdata[CTRL_BLOCK];
            flush   = hwdata[CTRL_FLUSH];
            clr     = hwdata[CTRL_CLR];
          end
          default: ;
        endcase
      end
      S_RD, S_STALL_RD: begin
        unique case (1'b1)
          addr_q == ADDR_DATA_OUT: begin
            if (!out_empty) begin
              rdata   = 32'(out_head);
              out_pop = 1'b1;
            end else if (!block_q) begin
              unf_set = 1'b1;
            end else if (ret && !drop) begin
              rdata  = 32'(data_log);
              bypass = 1'b1;
            end else begin
              done = 1'b0;
            end
          end
          addr_q == ADDR_STATUS: rdata = status;
          addr_q == ADDR_CTRL:   rdata = 32'(block_q);
          default: ;
        endcase
      end
      default: ;
    endcase
    if (!done) begin
      hready_o = 1'b0;
      state_d  = (state_q == S_WR || state_q == S_STALL_WR) ?
                 S_STALL_WR : S_STALL_RD;
    end else if (accept) begin
      state_d = hwrite ? S_WR : S_RD;
    end else begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    infl_d = infl_q + AW'(in_pop) - AW'(ret && (infl_q != '0));
    disc_d = disc_q;
    if (flush)     disc_d = infl_d;
    else if (drop) disc_d = disc_q - AW'(1);
    ovf_d = (flush | clr) ? 1'b0 : (ovf_q | ovf_set);
    unf_d = (flush | clr) ? 1'b0 : (unf_q | unf_set);
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      block_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      infl_q  <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept && hready_o) addr_q <= haddr[3:2];
      block_q <= block_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      infl_q  <= infl_d;
      disc_q  <= disc_d;
    end
  end

endmodule

// File: tb/tb_cm3_log_mc.sv
// Scoreboard bench for cm3_log_mc with a fixed-latency +1 core model.
module tb_cm3_log_mc;
  import cm3_log_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          hclk = 1'b0;
  logic          rst_n;
  logic          hready_i;
  logic          hsel;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [15:0]   haddr;
  logic [31:0]   hwdata;
  logic          hresp;
  logic          hready_o;
  logic [31:0]   hrdata;
  logic [DW-1:0] data_a;
  logic          data_a_valid;
  logic          data_a_ready;
  logic [DW-1:0] data_log;
  logic          data_log_valid;

  typedef struct {
    logic [31:0] val;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          lat = 2;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 hclk = ~hclk;
  assign hready_i = hready_o;

  cm3_log_mc #(.DW(DW), .DEPTH(DEPTH)) dut (
    .hclk           (hclk),
    .rst_n          (rst_n),
    .hready_i       (hready_i),
    .hsel           (hsel),
    .hwrite         (hwrite),
    .htrans         (htrans),
    .haddr          (haddr),
    .hwdata         (hwdata),
    .hresp          (hresp),
    .hready_o       (hready_o),
    .hrdata         (hrdata),
    .data_a         (data_a),
    .data_a_valid   (data_a_valid),
    .data_a_ready   (data_a_ready),
    .data_log       (data_log),
    .data_log_valid (data_log_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // core model: accepted operand returns +1, lat cycles after issue
  initial begin
    data_log_valid = 1'b0;
    data_log       = '0;
    forever begin
      @(negedge hclk);
      if (rst_n && data_a_valid && data_a_ready)
        pend.push_back(pend_t'{val: data_a + 1, due: cyc + 1 + lat});
      @(posedge hclk);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        data_log_valid = 1'b1;
        data_log       = pend[0].val;
        void'(pend.pop_front());
      end else begin
        data_log_valid = 1'b0;
        data_log       = '0;
      end
    end
  end

  task automatic bus_xfer(input logic wr, input logic [1:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rd, output int stalls);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = {12'h000, a, 2'b00};
    @(negedge hclk);
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hwdata = wd;
    stalls = 0;
    while (!hready_o && stalls < 200) begin
      @(negedge hclk);
      stalls++;
    end
    if (stalls >= 200) chk("hready_tmo", 32'(hready_o), 32'd1);
    rd = hrdata;
    @(negedge hclk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int s;
    bus_xfer(1'b1, a, d, rd, s);
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    int s;
    bus_xfer(1'b0, a, 32'h0, d, s);
  endtask

  task automatic push_op(input logic [31:0] v, input bit keep);
    wr_reg(ADDR_DATA_IN, v);
    if (keep) exp_q.push_back(v + 1);
  endtask

  task automatic pop_res(input string tag);
    logic [31:0] rd, ex;
    int s;
    bus_xfer(1'b0, ADDR_DATA_OUT, 32'h0, rd, s);
    if (exp_q.size() > 0) ex = exp_q.pop_front();
    else                  ex = 32'hDEAD_BEEF;
    chk(tag, rd, ex);
  endtask

  task automatic chk_status(input string tag, input logic [31:0] exp);
    logic [31:0] st;
    rd_reg(ADDR_STATUS, st);
    chk(tag, st, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, st;
    int          s, n;

    rst_n        = 1'b0;
    hsel         = 1'b0;
    hwrite       = 1'b0;
    htrans       = 2'b00;
    haddr        = '0;
    hwdata       = '0;
    data_a_ready = 1'b1;
    repeat (3) @(negedge hclk);
    rst_n = 1'b1;
    @(negedge hclk);

    chk("rst_hready", 32'(hready_o), 32'd1);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_avalid", 32'(data_a_valid), 32'd0);
    chk("rst_data_a", data_a, 32'h0);
    chk_status("rst_status", 32'h0002_0000);
    rd_reg(ADDR_CTRL, rd);
    chk("rst_ctrl", rd, 32'h1);

    // basic push/compute/pop
    push_op(32'h10, 1'b1);
    push_op(32'h20, 1'b1);
    push_op(32'h30, 1'b1);
    repeat (10) @(negedge hclk);
    pop_res("t1_r0");
    pop_res("t1_r1");
    pop_res("t1_r2");
    chk_status("t1_status", 32'h0002_0000);

    // blocking write on full input FIFO
    data_a_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_op(32'h100 + i, 1'b1);
    chk_status("t2_full", 32'h0003_0004);
    exp_q.push_back(32'h106);
    fork
      bus_xfer(1'b1, ADDR_DATA_IN, 32'h105, rd, s);
      begin
        repeat (5) @(posedge hclk);
        #1 data_a_ready = 1'b1;
      end
    join
    chk("t2_stalls", s, 32'd4);
    repeat (20) @(negedge hclk);
    for (int i = 0; i < 5; i++) pop_res("t2_res");
    chk_status("t2_status", 32'h0002_0000);

    // non-blocking overflow / underflow flags
    wr_reg(ADDR_CTRL, 32'h0);
    data_a_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_op(32'h200 + i, 1'b1);
    bus_xfer(1'b1, ADDR_DATA_IN, 32'h205, rd, s);
    chk("t3_nostall", s, 32'd0);
    chk_status("t3_ovf", 32'h0007_0004);
    data_a_ready = 1'b1;
    repeat (20) @(negedge hclk);
    for (int i = 0; i < 4; i++) pop_res("t3_res");
    bus_xfer(1'b0, ADDR_DATA_OUT, 32'h0, rd, s);
    chk("t3_unf_rd", rd, 32'h0);
    chk("t3_unf_stall", s, 32'd0);
    chk_status("t3_flags", 32'h000E_0000);
    wr_reg(ADDR_CTRL, 32'h4);
    chk_status("t3_clr", 32'h0002_0000);
    wr_reg(ADDR_CTRL, 32'h1);

    // blocked read with bypass from the core
    pend.push_back(pend_t'{val: 32'hABCD, due: cyc + 8});
    bus_xfer(1'b0, ADDR_DATA_OUT, 32'h0, rd, s);
    chk("t4_bypass", rd, 32'hABCD);
    chk("t4_stalls", s, 32'd7);
    chk_status("t4_status", 32'h0002_0000);

    // flush with results still in the core
    lat = 30;
    for (int i = 1; i <= 4; i++) push_op(32'h300 + i, 1'b0);
    repeat (2) @(negedge hclk);
    wr_reg(ADDR_CTRL, 32'h3);
    chk_status("t5_flushed", 32'h0012_0000);
    n = 0;
    do begin
      rd_reg(ADDR_STATUS, st);
      n++;
    end while (st[ST_BUSY] && n < 100);
    chk("t5_drained", st, 32'h0002_0000);
    lat = 2;
    push_op(32'h400, 1'b1);
    repeat (6) @(negedge hclk);
    pop_res("t5_fresh");

    // async reset during a blocked read
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = 1'b0;
    haddr  = {12'h000, ADDR_DATA_OUT, 2'b00};
    @(negedge hclk);
    hsel   = 1'b0;
    htrans = 2'b00;
    repeat (3) @(negedge hclk);
    chk("t6_stalled", 32'(hready_o), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_hready", 32'(hready_o), 32'd1);
    chk("t6_hrdata", hrdata, 32'h0);
    chk("t6_avalid", 32'(data_a_valid), 32'd0);
    chk("t6_data_a", data_a, 32'h0);
    pend.delete();
    exp_q.delete();
    @(negedge hclk);
    rst_n = 1'b1;
    @(negedge hclk);
    chk_status("t6_status", 32'h0002_0000);
    rd_reg(ADDR_CTRL, rd);
    chk("t6_ctrl", rd, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
